// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage.
// Holds the alu_op and funct encodings, the bit positions inside the
// execute and memory control buses, the multiplier step count and the
// execute FSM state type.
// The state type and MUL_STEPS are used only when MULDIV_EN is defined.
package exec_pkg;

  // alu_op field of the execute control bus
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  // funct codes carried in imm_in[5:0]
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // execute control bus bit positions
  localparam int EX_REG_DST   = 0;
  localparam int EX_ALU_SRC   = 1;
  localparam int EX_ALU_OP_LO = 2;
  localparam int EX_SHAMT_SRC = 5;
  localparam int EX_UNSIGNED  = 6;

  // memory control bus bit positions (forwarded untouched by this stage)
  localparam int MEM_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_BRANCH = 2;

  // one partial product per step of the shift-add multiplier
  localparam int MUL_STEPS = 32;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } ex_state_t;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU for the execute stage.
// Selects operand B (register or immediate), decodes alu_op and, for
// alu_op 111, the funct field in imm_in[5:0]; produces the result and a
// zero flag. Shift amount is imm_in[10:6] when shamt_src is set, else
// a_in[4:0]. The unsigned bit turns the alu_op SLT compare unsigned.
// Ports:
//   a_in, reg_b_in, imm_in         operands / immediate (funct, shamt)
//   alu_src, shamt_src, is_unsigned, alu_op  decoded execute controls
//   hi_in, lo_in                   HI/LO for MFHI/MFLO (MULDIV_EN only)
//   result_out, zero_out           result and (result == 0)
// Configuration: MULDIV_EN adds the hi_in/lo_in ports and MFHI/MFLO.
module alu_unit
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] reg_b_in,
  input  logic [DATA_WIDTH-1:0] imm_in,
  input  logic                  alu_src,
  input  logic                  shamt_src,
  input  logic                  is_unsigned,
  input  logic [2:0]            alu_op,
`ifdef MULDIV_EN
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
`endif
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  zero_out
);

  logic [DATA_WIDTH-1:0] b;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic                  lt_signed;
  logic                  lt_unsigned;

  assign b           = alu_src ? imm_in : reg_b_in;
  assign shamt       = shamt_src ? imm_in[10:6] : a_in[4:0];
  assign funct       = imm_in[5:0];
  assign lt_signed   = $signed(a_in) < $signed(b);
  assign lt_unsigned = a_in < b;

  always_comb begin
    result_out = '0;
    case (alu_op)
      ALU_ADD: result_out = a_in + b;
      ALU_SUB: result_out = a_in - b;
      ALU_AND: result_out = a_in & b;
      ALU_OR:  result_out = a_in | b;
      ALU_XOR: result_out = a_in ^ b;
      ALU_SLT: result_out = {{(DATA_WIDTH-1){1'b0}}, (is_unsigned ? lt_unsigned : lt_signed)};
      ALU_LUI: result_out = b << 16;
      default: begin
        case (funct)
          F_ADDU: result_out = a_in + b;
          F_SUBU: result_out = a_in - b;
          F_AND:  result_out = a_in & b;
          F_OR:   result_out = a_in | b;
          F_XOR:  result_out = a_in ^ b;
          F_NOR:  result_out = ~(a_in | b);
          F_SLT:  result_out = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
          F_SLTU: result_out = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
          F_SLL, F_SLLV: result_out = b << shamt;
          F_SRL, F_SRLV: result_out = b >> shamt;
          F_SRA, F_SRAV: result_out = $signed(b) >>> shamt;
`ifdef MULDIV_EN
          F_MFHI: result_out = hi_in;
          F_MFLO: result_out = lo_in;
`endif
          default: result_out = '0;
        endcase
      end
    endcase
  end

  assign zero_out = (result_out == '0);

endmodule

// File: rtl/iexecute.sv
// Execute pipeline stage.
// Computes the ALU result for the presented instruction and registers it
// with the forwarded memory/write-back controls, the store data, the
// destination register and the branch target (one cycle latency).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   valid_in, flush        instruction present / squash it
//   exec_bus_in            reg_dst, alu_src, alu_op[2:0], shamt_src, unsigned
//   mem_bus_in, wb_bus_in  controls forwarded to the next stage
//   pc_next_in, reg_a_in, reg_b_in, imm_in, rt_addr_in, rd_addr_in  data
//   stall_out              upstream holds its inputs while high
//   mem_bus_out .. branch_addr_out  registered stage outputs
// Configuration: MULDIV_EN adds a 32-step sequential shift-add multiplier
// (MULT/MULTU), HI/LO registers and MFHI/MFLO. Without it stall_out is 0.
//
// Handshake: an instruction is accepted at a rising edge when
// valid_in=1, flush=0 and stall_out=0. Anything else loads a bubble
// (mem/wb buses, ALU result, destination and zero flag all 0). While
// stall_out is high the producer must keep the next instruction steady;
// it is accepted on the first edge after stall_out falls.
module iexecute
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int EXEC_BUS_WIDTH = 7,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int REG_ADDR_BITS  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      flush,
  input  logic [EXEC_BUS_WIDTH-1:0] exec_bus_in,
  input  logic [MEM_BUS_WIDTH-1:0]  mem_bus_in,
  input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
  input  logic [DATA_WIDTH-1:0]     pc_next_in,
  input  logic [DATA_WIDTH-1:0]     reg_a_in,
  input  logic [DATA_WIDTH-1:0]     reg_b_in,
  input  logic [DATA_WIDTH-1:0]     imm_in,
  input  logic [REG_ADDR_BITS-1:0]  rt_addr_in,
  input  logic [REG_ADDR_BITS-1:0]  rd_addr_in,
  output logic                      stall_out,
  output logic [MEM_BUS_WIDTH-1:0]  mem_bus_out,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
  output logic [DATA_WIDTH-1:0]     alu_data_out,
  output logic                      alu_zero_flag,
  output logic [DATA_WIDTH-1:0]     store_data_out,
  output logic [REG_ADDR_BITS-1:0]  reg_w_addr_out,
  output logic [DATA_WIDTH-1:0]     branch_addr_out
);

  logic [2:0]            alu_op;
  logic [5:0]            funct;
  logic                  accept;
  logic                  mul_start;
  logic                  issue_bubble;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;

  assign alu_op = exec_bus_in[EX_ALU_OP_LO +: 3];
  assign funct  = imm_in[5:0];
  assign accept = valid_in & ~flush & ~stall_out;

`ifdef MULDIV_EN
  ex_state_t               state;
  ex_state_t               state_nxt;
  logic [4:0]              mul_cnt;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [DATA_WIDTH-1:0]   mcand_q;
  logic [2*DATA_WIDTH-1:0] prod_q;     // {partial sum, remaining multiplier bits}
  logic                    mul_neg_q;  // signed MULT with operands of opposite sign
  logic                    mul_signed;
  logic [DATA_WIDTH:0]     step_sum;
  logic [2*DATA_WIDTH-1:0] prod_step;
  logic [2*DATA_WIDTH-1:0] prod_final;

  assign mul_signed = (funct == F_MULT);
  assign mul_start  = accept && (alu_op == ALU_FUNCT) &&
                      ((funct == F_MULT) || (funct == F_MULTU));
  assign stall_out  = (state == MUL_BUSY);

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole product right.
  // Signed MULT runs on magnitudes and negates the final product.
  assign step_sum   = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step  = {step_sum, prod_q[DATA_WIDTH-1:1]};
  assign prod_final = mul_neg_q ? -prod_step : prod_step;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mul_start) state_nxt = MUL_BUSY;
      MUL_BUSY: if (mul_cnt == 5'(MUL_STEPS - 1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mul_cnt   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      mul_neg_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (mul_start) begin
          mul_cnt   <= '0;
          mcand_q   <= (mul_signed && reg_a_in[DATA_WIDTH-1]) ? -reg_a_in : reg_a_in;
          prod_q    <= {{DATA_WIDTH{1'b0}},
                        ((mul_signed && reg_b_in[DATA_WIDTH-1]) ? -reg_b_in : reg_b_in)};
          mul_neg_q <= mul_signed & (reg_a_in[DATA_WIDTH-1] ^ reg_b_in[DATA_WIDTH-1]);
        end
      end else begin
        prod_q  <= prod_step;
        mul_cnt <= mul_cnt + 5'd1;
        if (mul_cnt == 5'(MUL_STEPS - 1)) begin
          hi_q <= prod_final[2*DATA_WIDTH-1:DATA_WIDTH];
          lo_q <= prod_final[DATA_WIDTH-1:0];
        end
      end
    end
  end
`else
  assign mul_start = 1'b0;
  assign stall_out = 1'b0;
`endif

  // An accepted multiply occupies the unit but writes nothing itself.
  assign issue_bubble = ~accept | mul_start;

  alu_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .a_in        (reg_a_in),
    .reg_b_in    (reg_b_in),
    .imm_in      (imm_in),
    .alu_src     (exec_bus_in[EX_ALU_SRC]),
    .shamt_src   (exec_bus_in[EX_SHAMT_SRC]),
    .is_unsigned (exec_bus_in[EX_UNSIGNED]),
    .alu_op      (alu_op),
`ifdef MULDIV_EN
    .hi_in       (hi_q),
    .lo_in       (lo_q),
`endif
    .result_out  (alu_result),
    .zero_out    (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_bus_out     <= '0;
      wb_bus_out      <= '0;
      alu_data_out    <= '0;
      alu_zero_flag   <= 1'b0;
      store_data_out  <= '0;
      reg_w_addr_out  <= '0;
      branch_addr_out <= '0;
    end else begin
      // Store data and branch target are only consumed alongside a real
      // instruction, so they follow the inputs unconditionally.
      store_data_out  <= reg_b_in;
      branch_addr_out <= pc_next_in + (imm_in << 2);
      if (issue_bubble) begin
        mem_bus_out    <= '0;
        wb_bus_out     <= '0;
        alu_data_out   <= '0;
        alu_zero_flag  <= 1'b0;
        reg_w_addr_out <= '0;
      end else begin
        mem_bus_out    <= mem_bus_in;
        wb_bus_out     <= wb_bus_in;
        alu_data_out   <= alu_result;
        alu_zero_flag  <= alu_zero;
        reg_w_addr_out <= exec_bus_in[EX_REG_DST] ? rd_addr_in : rt_addr_in;
      end
    end
  end

endmodule

// File: tb/tb_iexecute.sv
// Bench for iexecute: directed vectors, a behavioural model of the stage
// checked against the outputs every cycle, and literal expectations for
// the documented scenarios.
module tb_iexecute;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic [6:0]  exec_bus_in = '0;
  logic [2:0]  mem_bus_in = '0;
  logic [1:0]  wb_bus_in = '0;
  logic [31:0] pc_next_in = '0;
  logic [31:0] reg_a_in = '0;
  logic [31:0] reg_b_in = '0;
  logic [31:0] imm_in = '0;
  logic [4:0]  rt_addr_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        stall_out;
  logic [2:0]  mem_bus_out;
  logic [1:0]  wb_bus_out;
  logic [31:0] alu_data_out;
  logic        alu_zero_flag;
  logic [31:0] store_data_out;
  logic [4:0]  reg_w_addr_out;
  logic [31:0] branch_addr_out;

  always #5 clk = ~clk;

  iexecute dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .flush           (flush),
    .exec_bus_in     (exec_bus_in),
    .mem_bus_in      (mem_bus_in),
    .wb_bus_in       (wb_bus_in),
    .pc_next_in      (pc_next_in),
    .reg_a_in        (reg_a_in),
    .reg_b_in        (reg_b_in),
    .imm_in          (imm_in),
    .rt_addr_in      (rt_addr_in),
    .rd_addr_in      (rd_addr_in),
    .stall_out       (stall_out),
    .mem_bus_out     (mem_bus_out),
    .wb_bus_out      (wb_bus_out),
    .alu_data_out    (alu_data_out),
    .alu_zero_flag   (alu_zero_flag),
    .store_data_out  (store_data_out),
    .reg_w_addr_out  (reg_w_addr_out),
    .branch_addr_out (branch_addr_out)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- encoding helpers ----------------
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SLT = 3'd5, OP_LUI = 3'd6, OP_FN = 3'd7;

  function automatic logic [6:0] ex(input logic rdst, input logic src, input logic [2:0] op,
                                    input logic sh, input logic uns);
    return {uns, sh, op, src, rdst};
  endfunction

  function automatic logic [31:0] r_imm(input logic [5:0] fn, input logic [4:0] sh);
    return {21'd0, sh, fn};
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_alu(input logic [6:0] e, input logic [31:0] a,
      input logic [31:0] rb, input logic [31:0] imm, input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] b;
    logic [4:0]  sh;
    logic [63:0] wide;
    b  = e[1] ? imm : rb;
    sh = e[5] ? imm[10:6] : a[4:0];
    wide = {{32{b[31]}}, b} >> sh;
    case (e[4:2])
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return e[6] ? 32'(a < b) : 32'($signed(a) < $signed(b));
      3'd6: return {b[15:0], 16'h0000};
      default: begin
        case (imm[5:0])
          6'h21: return a + b;
          6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2A: return 32'($signed(a) < $signed(b));
          6'h2B: return 32'(a < b);
          6'h00, 6'h04: return b << sh;
          6'h02, 6'h06: return b >> sh;
          6'h03, 6'h07: return wide[31:0];
`ifdef MULDIV_EN
          6'h10: return hi;
          6'h12: return lo;
`endif
          default: return 32'h0;
        endcase
      end
    endcase
  endfunction

  int          m_busy = 0;    // stall cycles still to come
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  logic [2:0]  e_mem;
  logic [1:0]  e_wb;
  logic [31:0] e_alu, e_store, e_branch;
  logic        e_zero;
  logic [4:0]  e_regw;
  bit          e_full;        // zero flag / store / branch meaningful

  always @(posedge clk) begin : model
    bit stall_now, acc, is_mul;
    longint sa, sb;
    if (reset) begin
      m_busy = 0; m_hi = '0; m_lo = '0;
      e_mem = '0; e_wb = '0; e_alu = '0; e_zero = 1'b0;
      e_store = '0; e_regw = '0; e_branch = '0; e_full = 1'b1;
    end else begin
      stall_now = (m_busy > 0);
      acc = valid_in && !flush && !stall_now;
      is_mul = 1'b0;
`ifdef MULDIV_EN
      is_mul = acc && exec_bus_in[4:2] == 3'd7 && (imm_in[5:0] == 6'h18 || imm_in[5:0] == 6'h19);
`endif
      e_store = reg_b_in;
      e_branch = pc_next_in + imm_in * 4;
      if (acc && !is_mul) begin
        e_full = 1'b1;
        e_mem = mem_bus_in;
        e_wb = wb_bus_in;
        e_alu = model_alu(exec_bus_in, reg_a_in, reg_b_in, imm_in, m_hi, m_lo);
        e_zero = (e_alu == 0);
        e_regw = exec_bus_in[0] ? rd_addr_in : rt_addr_in;
      end else begin
        e_full = 1'b0;
        e_mem = '0; e_wb = '0; e_alu = '0; e_regw = '0;
      end
      if (stall_now) begin
        m_busy--;
        if (m_busy == 0) begin
          m_hi = m_pend[63:32];
          m_lo = m_pend[31:0];
        end
      end
      if (is_mul) begin
        m_busy = 32;
        if (imm_in[0]) begin
          m_pend = {32'd0, reg_a_in} * {32'd0, reg_b_in};
        end else begin
          sa = longint'($signed(reg_a_in));
          sb = longint'($signed(reg_b_in));
          m_pend = 64'(sa * sb);
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall_out), 32'(m_busy > 0));
      check("mem_bus", 32'(mem_bus_out), 32'(e_mem));
      check("wb_bus", 32'(wb_bus_out), 32'(e_wb));
      check("alu_data", alu_data_out, e_alu);
      check("reg_w_addr", 32'(reg_w_addr_out), 32'(e_regw));
      if (e_full) begin
        check("zero_flag", 32'(alu_zero_flag), 32'(e_zero));
        check("store_data", store_data_out, e_store);
        check("branch_addr", branch_addr_out, e_branch);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [6:0] e, input logic [2:0] m, input logic [1:0] w,
                     input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
    valid_in = 1'b1; flush = 1'b0;
    exec_bus_in = e; mem_bus_in = m; wb_bus_in = w; pc_next_in = pc;
    reg_a_in = a; reg_b_in = b; imm_in = imm; rt_addr_in = rt; rd_addr_in = rd;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int vec_n = 0;
  task automatic vec(input logic [6:0] e, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] imm);
    put(e, vec_n[2:0], vec_n[1:0], 32'(vec_n * 16), a, b, imm, vec_n[4:0], ~vec_n[4:0]);
    step();
    vec_n++;
  endtask

  // Holds the next instruction (already on the inputs) through the stall;
  // returns the number of sampled stall cycles, bounded.
  task automatic wait_stall(output int n);
    n = 0;
    while (stall_out && n < 40) begin
      n++;
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (2) step();
    check("rst_stall", 32'(stall_out), 32'h0);
    check("rst_mem", 32'(mem_bus_out), 32'h0);
    check("rst_wb", 32'(wb_bus_out), 32'h0);
    check("rst_alu", alu_data_out, 32'h0);
    check("rst_zero", 32'(alu_zero_flag), 32'h0);
    check("rst_store", store_data_out, 32'h0);
    check("rst_regw", 32'(reg_w_addr_out), 32'h0);
    check("rst_branch", branch_addr_out, 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    // ADD wrapping to zero
    put(ex(0, 0, OP_ADD, 0, 0), 3'b000, 2'b01, 32'h40, 32'd5, 32'hFFFF_FFFB, 32'h0, 5'd3, 5'd4);
    step();
    check("add_alu", alu_data_out, 32'h0);
    check("add_zero", 32'(alu_zero_flag), 32'h1);
    check("add_regw", 32'(reg_w_addr_out), 32'd3);

    // BEQ-style compare and branch target
    put(ex(0, 0, OP_SUB, 0, 0), 3'b100, 2'b00, 32'h100, 32'd7, 32'd7, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step();
    check("beq_branch", branch_addr_out, 32'h0000_00FC);
    check("beq_zero", 32'(alu_zero_flag), 32'h1);
    check("beq_mem", 32'(mem_bus_out), 32'h4);

    // SRA by shamt
    put(ex(1, 0, OP_FN, 1, 0), 3'b000, 2'b01, 32'h0, 32'h0, 32'h8000_0000, r_imm(6'h03, 5'd4), 5'd2, 5'd9);
    step();
    check("sra_alu", alu_data_out, 32'hF800_0000);
    check("sra_regw", 32'(reg_w_addr_out), 32'd9);

    // operation sweep, checked by the model
    vec(ex(1, 0, OP_SUB, 0, 0), 32'd3, 32'd5, 32'h0);
    vec(ex(0, 0, OP_AND, 0, 0), 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h0);
    vec(ex(1, 0, OP_OR, 0, 0), 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h0);
    vec(ex(0, 0, OP_XOR, 0, 0), 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h0);
    vec(ex(0, 0, OP_SLT, 0, 0), 32'hFFFF_FFFF, 32'd1, 32'h0);
    vec(ex(0, 0, OP_SLT, 0, 1), 32'hFFFF_FFFF, 32'd1, 32'h0);
    vec(ex(0, 1, OP_ADD, 0, 0), 32'h10, 32'h5, 32'hFFFF_FFF0);
    vec(ex(0, 1, OP_LUI, 0, 0), 32'h0, 32'h0, 32'h0000_1234);
    check("lui_alu", alu_data_out, 32'h1234_0000);
    vec(ex(1, 0, OP_FN, 0, 0), 32'h7FFF_FFFF, 32'd1, 32'h21);
    vec(ex(1, 0, OP_FN, 0, 0), 32'h0, 32'd1, 32'h23);
    vec(ex(1, 0, OP_FN, 0, 0), 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h24);
    vec(ex(1, 0, OP_FN, 0, 0), 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h25);
    vec(ex(1, 0, OP_FN, 0, 0), 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h26);
    vec(ex(1, 0, OP_FN, 0, 0), 32'h0, 32'hF0F0_F0F0, 32'h27);
    check("nor_alu", alu_data_out, 32'h0F0F_0F0F);
    vec(ex(1, 0, OP_FN, 0, 0), 32'h8000_0000, 32'd1, 32'h2A);
    check("slt_alu", alu_data_out, 32'h1);
    vec(ex(1, 0, OP_FN, 0, 0), 32'h8000_0000, 32'd1, 32'h2B);
    vec(ex(1, 0, OP_FN, 1, 0), 32'h0, 32'd3, r_imm(6'h00, 5'd31));
    vec(ex(1, 0, OP_FN, 1, 0), 32'h0, 32'h8000_0000, r_imm(6'h02, 5'd8));
    vec(ex(1, 0, OP_FN, 0, 0), 32'd4, 32'd1, 32'h04);
    vec(ex(1, 0, OP_FN, 0, 0), 32'h24, 32'hF0, 32'h06);
    vec(ex(1, 0, OP_FN, 0, 0), 32'd1, 32'h8000_0000, 32'h07);
    check("srav_alu", alu_data_out, 32'hC000_0000);
    vec(ex(1, 0, OP_FN, 0, 0), 32'd9, 32'd9, 32'h3F);
    check("badfn_alu", alu_data_out, 32'h0);

    // bubbles
    put(ex(1, 0, OP_ADD, 0, 0), 3'b111, 2'b11, 32'h0, 32'd1, 32'd1, 32'h0, 5'd7, 5'd8);
    valid_in = 1'b0;
    step();
    check("invalid_wb", 32'(wb_bus_out), 32'h0);
    valid_in = 1'b1; flush = 1'b1;
    step();
    check("flush_wb", 32'(wb_bus_out), 32'h0);
    check("flush_regw", 32'(reg_w_addr_out), 32'h0);
    flush = 1'b0;

`ifdef MULDIV_EN
    // MULTU, MFLO held through the stall, then MFHI
    put(ex(0, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'h19, 5'd1, 5'd2);
    step();
    check("multu_wb_bubble", 32'(wb_bus_out), 32'h0);
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd5);
    wait_stall(n);
    check("multu_stall_cycles", 32'(n), 32'd32);
    step();
    check("mflo_alu", alu_data_out, 32'hFFFF_FFFE);
    check("mflo_regw", 32'(reg_w_addr_out), 32'd5);
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd6);
    step();
    check("mfhi_alu", alu_data_out, 32'h1);

    // signed MULT with flush asserted during the busy period
    put(ex(0, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'hFFFF_FFFD, 32'd5, 32'h18, 5'd1, 5'd2);
    step();
    put(ex(1, 0, OP_ADD, 0, 0), 3'b000, 2'b11, 32'h0, 32'd1, 32'd1, 32'h0, 5'd0, 5'd3);
    flush = 1'b1;
    wait_stall(n);
    check("mult_flush_busy_cycles", 32'(n), 32'd32);
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd5);
    step();
    check("mult_lo", alu_data_out, 32'hFFFF_FFF1);
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd5);
    step();
    check("mult_hi", alu_data_out, 32'hFFFF_FFFF);

    // flushed MULT must not start nor touch HI/LO
    put(ex(0, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'd2, 32'd2, 32'h18, 5'd1, 5'd2);
    flush = 1'b1;
    step();
    check("flushed_mult_stall", 32'(stall_out), 32'h0);
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd5);
    step();
    check("flushed_mult_lo", alu_data_out, 32'hFFFF_FFF1);

    // reset at busy cycle 10
    put(ex(0, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'd7, 32'd9, 32'h19, 5'd1, 5'd2);
    step();
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd5);
    repeat (9) step();
    check("busy10_stall", 32'(stall_out), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_stall", 32'(stall_out), 32'h0);
    check("mrst_alu", alu_data_out, 32'h0);
    check("mrst_wb", 32'(wb_bus_out), 32'h0);
    check("mrst_branch", branch_addr_out, 32'h0);
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd5);
    step();
    check("mrst_mfhi", alu_data_out, 32'h0);
    check("mrst_mfhi_wb", 32'(wb_bus_out), 32'h1);
`else
    // without the multiplier, MULT/MFLO are ordinary instructions yielding 0
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b11, 32'h0, 32'd3, 32'd3, 32'h18, 5'd1, 5'd2);
    step();
    check("nomul_stall", 32'(stall_out), 32'h0);
    check("nomul_wb", 32'(wb_bus_out), 32'h3);
    check("nomul_alu", alu_data_out, 32'h0);
    put(ex(1, 0, OP_FN, 0, 0), 3'b000, 2'b01, 32'h0, 32'd3, 32'd3, 32'h12, 5'd1, 5'd2);
    step();
    check("nomul_mflo", alu_data_out, 32'h0);
`endif

    valid_in = 1'b0;
    repeat (3) step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
